core_debug_unit: RTL and testbench

CORE_DEBUG_UNIT -- requirements
Module: core_debug_unit

---
 rtl/core_debug_unit.sv | 208 ++++++++++++++++++++
 tb/tb_core_debug_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_debug_unit.sv
`default_nettype none
// ============================================================================
// Module   : core_debug_unit
// Purpose  : Debugger command sequencer for halt, step, register and memory access.
//            The memory access path is built only when DEBUG_MEM_ACCESS_EN is defined.
// Revision : 1.0
// ============================================================================
module core_debug_unit #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_debug_command,
    input  logic        send_debug_command_data_argument,
    input  logic        send_debug_command_address_argument,
    input  logic [31:0] debug_bus,
    output logic        core_busy,
    output logic [31:0] debug_result,
    output logic        core_halt,
    output logic        core_step,
    input  logic        core_retired,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_we,
    input  logic [31:0] reg_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GET_DATA  = 3'd1;
    localparam logic [2:0] S_GET_ADDR  = 3'd2;
    localparam logic [2:0] S_EXEC      = 3'd3;
`ifdef DEBUG_MEM_ACCESS_EN
    localparam logic [2:0] S_MEM_WAIT  = 3'd4;
`endif
    localparam logic [2:0] S_STEP_WAIT = 3'd5;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_HALT      = 3'd1;
    localparam logic [2:0] OP_RESUME    = 3'd2;
    localparam logic [2:0] OP_STEP      = 3'd3;
    localparam logic [2:0] OP_READ_REG  = 3'd4;
    localparam logic [2:0] OP_WRITE_REG = 3'd5;
    localparam logic [2:0] OP_READ_MEM  = 3'd6;
    localparam logic [2:0] OP_WRITE_MEM = 3'd7;

    localparam logic [31:0] RES_ERROR   = 32'hFFFF_FFFF;
`ifdef DEBUG_MEM_ACCESS_EN
    localparam logic [31:0] RES_TIMEOUT = 32'hFFFF_FFFE;
    localparam int          TW          = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
`endif

    logic [2:0]  state;
    logic [2:0]  opcode;
    logic [31:0] data_arg;
    logic [31:0] addr_arg;
    logic        in_exec;

`ifdef DEBUG_MEM_ACCESS_EN
    logic [TW-1:0] timeout_cnt;
`endif

    // Side-effect strobes are decoded from EXEC so they last exactly one cycle.
    always_comb begin
        in_exec   = (state == S_EXEC);
        core_step = in_exec && (opcode == OP_STEP) && core_halt;
        reg_we    = in_exec && (opcode == OP_WRITE_REG) && core_halt && (addr_arg[4:0] != 5'd0);
        reg_addr  = addr_arg[4:0];
        reg_wdata = data_arg;
        mem_addr  = addr_arg;
        mem_wdata = data_arg;
    end

`ifdef DEBUG_MEM_ACCESS_EN
    assign mem_we = mem_req && (opcode == OP_WRITE_MEM);
`else
    logic unused_mem;
    assign mem_req    = 1'b0;
    assign mem_we     = 1'b0;
    assign unused_mem = &{1'b0, mem_ready, mem_rdata, (MEM_TIMEOUT > 0)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            opcode       <= 3'd0;
            data_arg     <= 32'd0;
            addr_arg     <= 32'd0;
            core_busy    <= 1'b0;
            core_halt    <= 1'b0;
            debug_result <= 32'd0;
`ifdef DEBUG_MEM_ACCESS_EN
            mem_req      <= 1'b0;
            timeout_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (send_debug_command) begin
                        opcode    <= debug_bus[2:0];
                        core_busy <= 1'b1;
                        state     <= S_GET_DATA;
                    end
                end

                S_GET_DATA: begin
                    if (send_debug_command) begin
                        opcode <= debug_bus[2:0];
                    end else if (send_debug_command_data_argument) begin
                        data_arg <= debug_bus;
                        state    <= S_GET_ADDR;
                    end
                end

                S_GET_ADDR: begin
                    if (send_debug_command) begin
                        opcode <= debug_bus[2:0];
                        state  <= S_GET_DATA;
                    end else if (send_debug_command_address_argument) begin
                        addr_arg <= debug_bus;
                        state    <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    // Single-cycle completion unless a multi-cycle command overrides below.
                    state     <= S_IDLE;
                    core_busy <= 1'b0;
                    case (opcode)
                        OP_NOP: debug_result <= 32'd0;
                        OP_HALT: begin
                            core_halt    <= 1'b1;
                            debug_result <= 32'd0;
                        end
                        OP_RESUME: begin
                            core_halt    <= 1'b0;
                            debug_result <= 32'd0;
                        end
                        OP_STEP: begin
                            if (!core_halt) begin
                                debug_result <= RES_ERROR;
                            end else if (core_retired) begin
                                debug_result <= 32'd1;
                            end else begin
                                state     <= S_STEP_WAIT;
                                core_busy <= 1'b1;
                            end
                        end
                        OP_READ_REG:  debug_result <= core_halt ? reg_rdata : RES_ERROR;
                        OP_WRITE_REG: debug_result <= core_halt ? 32'd0 : RES_ERROR;
                        OP_READ_MEM, OP_WRITE_MEM: begin
`ifdef DEBUG_MEM_ACCESS_EN
                            if (!core_halt) begin
                                debug_result <= RES_ERROR;
                            end else begin
                                state       <= S_MEM_WAIT;
                                core_busy   <= 1'b1;
                                mem_req     <= 1'b1;
                                timeout_cnt <= '0;
                            end
`else
                            debug_result <= RES_ERROR;
`endif
                        end
                    endcase
                end

`ifdef DEBUG_MEM_ACCESS_EN
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        mem_req      <= 1'b0;
                        core_busy    <= 1'b0;
                        state        <= S_IDLE;
                        debug_result <= (opcode == OP_READ_MEM) ? mem_rdata : 32'd0;
                    end else if (timeout_cnt == TW'(MEM_TIMEOUT - 1)) begin
                        mem_req      <= 1'b0;
                        core_busy    <= 1'b0;
                        state        <= S_IDLE;
                        debug_result <= RES_TIMEOUT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
`endif

                S_STEP_WAIT: begin
                    if (core_retired) begin
                        debug_result <= 32'd1;
                        core_busy    <= 1'b0;
                        state        <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    core_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_debug_unit.sv
`default_nettype none
// Directed testbench for core_debug_unit with a small register-file model.
module tb_core_debug_unit;

    logic        clk;
    logic        rst;
    logic        send_cmd, send_data, send_addr;
    logic [31:0] debug_bus;
    logic        core_busy;
    logic [31:0] debug_result;
    logic        core_halt, core_step, core_retired;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ready;

    int tests;
    int failed;
    int we_cnt, step_cnt, memreq_cnt, busy_cnt;
    logic [31:0] regs [32];
    logic [4:0]  last_we_addr;
    logic [31:0] last_we_data;

    core_debug_unit #(.MEM_TIMEOUT(64)) dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .send_debug_command                  (send_cmd),
        .send_debug_command_data_argument    (send_data),
        .send_debug_command_address_argument (send_addr),
        .debug_bus                           (debug_bus),
        .core_busy                           (core_busy),
        .debug_result                        (debug_result),
        .core_halt                           (core_halt),
        .core_step                           (core_step),
        .core_retired                        (core_retired),
        .reg_addr                            (reg_addr),
        .reg_wdata                           (reg_wdata),
        .reg_we                              (reg_we),
        .reg_rdata                           (reg_rdata),
        .mem_addr                            (mem_addr),
        .mem_wdata                           (mem_wdata),
        .mem_req                             (mem_req),
        .mem_we                              (mem_we),
        .mem_ready                           (mem_ready),
        .mem_rdata                           (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign reg_rdata = regs[reg_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'hA5A5_0000 | 32'(i);
            we_cnt     <= 0;
            step_cnt   <= 0;
            memreq_cnt <= 0;
            busy_cnt   <= 0;
        end else begin
            if (reg_we) begin
                regs[reg_addr] <= reg_wdata;
                last_we_addr   <= reg_addr;
                last_we_data   <= reg_wdata;
                we_cnt         <= we_cnt + 1;
            end
            if (core_step) step_cnt   <= step_cnt + 1;
            if (mem_req)   memreq_cnt <= memreq_cnt + 1;
            if (core_busy) busy_cnt   <= busy_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Drives one frame; returns at the falling edge inside the EXEC cycle.
    task automatic frame(input logic [31:0] op, input logic [31:0] data, input logic [31:0] addr);
        @(negedge clk); send_cmd = 1'b1; debug_bus = op;
        @(negedge clk); send_cmd = 1'b0; send_data = 1'b1; debug_bus = data;
        @(negedge clk); send_data = 1'b0; send_addr = 1'b1; debug_bus = addr;
        @(negedge clk); send_addr = 1'b0; debug_bus = 32'd0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (core_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (core_busy !== 1'b0) begin
            failed++;
            $display("FAIL wait_idle: core_busy=%b after %0d cycles, expected 0", core_busy, limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; send_cmd = 1'b0; send_data = 1'b0; send_addr = 1'b0;
        debug_bus = 32'd0; core_retired = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++; if (core_busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", core_busy); end
        tests++; if (core_halt !== 1'b0) begin failed++; $display("FAIL reset_halt: got %b expected 0", core_halt); end
        tests++; if (core_step !== 1'b0) begin failed++; $display("FAIL reset_step: got %b expected 0", core_step); end
        tests++; if (reg_we !== 1'b0) begin failed++; $display("FAIL reset_reg_we: got %b expected 0", reg_we); end
        tests++; if (mem_req !== 1'b0) begin failed++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        tests++; if (mem_we !== 1'b0) begin failed++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        tests++; if (debug_result !== 32'd0) begin failed++; $display("FAIL reset_result: got %h expected 00000000", debug_result); end
    endtask

    task automatic test_not_halted();
        int s;
        s = step_cnt;
        frame(32'd3, 32'd0, 32'd0);
        tests++; if (core_step !== 1'b0) begin failed++; $display("FAIL nh_step_pulse: got %b expected 0", core_step); end
        wait_idle(8);
        tests++; if (debug_result !== 32'hFFFF_FFFF) begin failed++; $display("FAIL nh_step_result: got %h expected ffffffff", debug_result); end
        tests++; if (step_cnt - s !== 0) begin failed++; $display("FAIL nh_step_count: got %0d expected 0", step_cnt - s); end
        frame(32'd0, 32'd0, 32'd0);
        wait_idle(8);
        tests++; if (debug_result !== 32'd0) begin failed++; $display("FAIL nop_result: got %h expected 00000000", debug_result); end
        frame(32'd4, 32'd0, 32'd5);
        wait_idle(8);
        tests++; if (debug_result !== 32'hFFFF_FFFF) begin failed++; $display("FAIL nh_readreg_result: got %h expected ffffffff", debug_result); end
        tests++; if (core_halt !== 1'b0) begin failed++; $display("FAIL nh_halt: got %b expected 0", core_halt); end
    endtask

    task automatic test_halt();
        int b;
        b = busy_cnt;
        frame(32'hABCD_EF01, 32'd0, 32'd0);
        wait_idle(8);
        tests++; if (busy_cnt - b !== 3) begin failed++; $display("FAIL halt_busy_cycles: got %0d expected 3", busy_cnt - b); end
        tests++; if (core_halt !== 1'b1) begin failed++; $display("FAIL halt_halt: got %b expected 1", core_halt); end
        tests++; if (debug_result !== 32'd0) begin failed++; $display("FAIL halt_result: got %h expected 00000000", debug_result); end
    endtask

    task automatic test_registers();
        int w;
        w = we_cnt;
        frame(32'd5, 32'h1234_5678, 32'd5);
        tests++; if (reg_we !== 1'b1) begin failed++; $display("FAIL wr_we_exec: got %b expected 1", reg_we); end
        tests++; if (reg_addr !== 5'd5) begin failed++; $display("FAIL wr_addr_exec: got %0d expected 5", reg_addr); end
        wait_idle(8);
        tests++; if (we_cnt - w !== 1) begin failed++; $display("FAIL wr_we_count: got %0d expected 1", we_cnt - w); end
        tests++; if (last_we_addr !== 5'd5 || last_we_data !== 32'h1234_5678) begin failed++; $display("FAIL wr_target: got %0d/%h expected 5/12345678", last_we_addr, last_we_data); end
        tests++; if (debug_result !== 32'd0) begin failed++; $display("FAIL wr_result: got %h expected 00000000", debug_result); end
        frame(32'd4, 32'd0, 32'd5);
        wait_idle(8);
        tests++; if (debug_result !== 32'h1234_5678) begin failed++; $display("FAIL rd5_result: got %h expected 12345678", debug_result); end
        frame(32'd4, 32'd0, 32'd9);
        wait_idle(8);
        tests++; if (debug_result !== 32'hA5A5_0009) begin failed++; $display("FAIL rd9_result: got %h expected a5a50009", debug_result); end
        w = we_cnt;
        frame(32'd5, 32'hFFFF_0000, 32'hFFFF_FFE0);
        tests++; if (reg_we !== 1'b0) begin failed++; $display("FAIL wr0_we_exec: got %b expected 0", reg_we); end
        wait_idle(8);
        tests++; if (we_cnt - w !== 0) begin failed++; $display("FAIL wr0_we_count: got %0d expected 0", we_cnt - w); end
        tests++; if (debug_result !== 32'd0) begin failed++; $display("FAIL wr0_result: got %h expected 00000000", debug_result); end
    endtask

    task automatic test_step();
        int s;
        frame(32'd0, 32'd0, 32'd0);
        wait_idle(8);
        s = step_cnt;
        frame(32'd3, 32'd0, 32'd0);
        tests++; if (core_step !== 1'b1) begin failed++; $display("FAIL step_pulse: got %b expected 1", core_step); end
        repeat (3) @(negedge clk);
        tests++; if (core_busy !== 1'b1) begin failed++; $display("FAIL step_wait_busy: got %b expected 1", core_busy); end
        @(negedge clk); core_retired = 1'b1;
        @(negedge clk); core_retired = 1'b0;
        tests++; if (core_busy !== 1'b0) begin failed++; $display("FAIL step_done_busy: got %b expected 0", core_busy); end
        tests++; if (debug_result !== 32'd1) begin failed++; $display("FAIL step_result: got %h expected 00000001", debug_result); end
        tests++; if (step_cnt - s !== 1) begin failed++; $display("FAIL step_count: got %0d expected 1", step_cnt - s); end
        tests++; if (core_halt !== 1'b1) begin failed++; $display("FAIL step_halt: got %b expected 1", core_halt); end
        frame(32'd0, 32'd0, 32'd0);
        wait_idle(8);
        frame(32'd3, 32'd0, 32'd0);
        core_retired = 1'b1;
        @(negedge clk); core_retired = 1'b0;
        tests++; if (core_busy !== 1'b0) begin failed++; $display("FAIL step_same_busy: got %b expected 0", core_busy); end
        tests++; if (debug_result !== 32'd1) begin failed++; $display("FAIL step_same_result: got %h expected 00000001", debug_result); end
    endtask

    task automatic test_memory();
        int m;
`ifdef DEBUG_MEM_ACCESS_EN
        frame(32'd6, 32'd0, 32'h0000_0100);
        @(negedge clk);
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin failed++; $display("FAIL mrd_req: got req=%b addr=%h we=%b expected 1/00000100/0", mem_req, mem_addr, mem_we); end
        repeat (2) @(negedge clk);
        @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk); mem_ready = 1'b0; mem_rdata = 32'd0;
        tests++; if (mem_req !== 1'b0 || core_busy !== 1'b0) begin failed++; $display("FAIL mrd_drop: got req=%b busy=%b expected 0/0", mem_req, core_busy); end
        tests++; if (debug_result !== 32'hCAFE_F00D) begin failed++; $display("FAIL mrd_result: got %h expected cafef00d", debug_result); end
        m = memreq_cnt;
        frame(32'd6, 32'd0, 32'h0000_0200);
        wait_idle(200);
        tests++; if (debug_result !== 32'hFFFF_FFFE) begin failed++; $display("FAIL mto_result: got %h expected fffffffe", debug_result); end
        tests++; if (memreq_cnt - m !== 64) begin failed++; $display("FAIL mto_cycles: got %0d expected 64", memreq_cnt - m); end
        frame(32'd7, 32'hDEAD_BEEF, 32'h0000_0040);
        @(negedge clk);
        tests++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL mwr_req: got we=%b wdata=%h expected 1/deadbeef", mem_we, mem_wdata); end
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        tests++; if (debug_result !== 32'd0) begin failed++; $display("FAIL mwr_result: got %h expected 00000000", debug_result); end
`else
        m = memreq_cnt;
        frame(32'd6, 32'd0, 32'h0000_0100);
        tests++; if (mem_req !== 1'b0) begin failed++; $display("FAIL mdis_req: got %b expected 0", mem_req); end
        wait_idle(8);
        tests++; if (debug_result !== 32'hFFFF_FFFF) begin failed++; $display("FAIL mdis_rd_result: got %h expected ffffffff", debug_result); end
        frame(32'd0, 32'd0, 32'd0);
        wait_idle(8);
        frame(32'd7, 32'h1, 32'h0000_0100);
        wait_idle(8);
        tests++; if (debug_result !== 32'hFFFF_FFFF) begin failed++; $display("FAIL mdis_wr_result: got %h expected ffffffff", debug_result); end
        tests++; if (memreq_cnt - m !== 0 || mem_we !== 1'b0) begin failed++; $display("FAIL mdis_req_count: got %0d/%b expected 0/0", memreq_cnt - m, mem_we); end
`endif
    endtask

    task automatic test_restart();
        frame(32'd0, 32'd0, 32'd0);
        wait_idle(8);
        @(negedge clk); send_cmd = 1'b1; debug_bus = 32'd0;
        @(negedge clk); send_cmd = 1'b0; send_data = 1'b1; debug_bus = 32'd7;
        @(negedge clk); send_data = 1'b0; send_cmd = 1'b1; debug_bus = 32'd4;
        @(negedge clk); send_cmd = 1'b0; send_addr = 1'b1; debug_bus = 32'd3;
        @(negedge clk); send_addr = 1'b0; send_data = 1'b1; debug_bus = 32'd0;
        @(negedge clk); send_data = 1'b0; send_addr = 1'b1; debug_bus = 32'd9;
        @(negedge clk); send_addr = 1'b0; debug_bus = 32'd0;
        tests++; if (core_busy !== 1'b1) begin failed++; $display("FAIL restart_busy: got %b expected 1", core_busy); end
        wait_idle(8);
        tests++; if (debug_result !== 32'hA5A5_0009) begin failed++; $display("FAIL restart_result: got %h expected a5a50009", debug_result); end
    endtask

    task automatic test_resume();
        frame(32'd2, 32'd0, 32'd0);
        wait_idle(8);
        tests++; if (core_halt !== 1'b0) begin failed++; $display("FAIL resume_halt: got %b expected 0", core_halt); end
        tests++; if (debug_result !== 32'd0) begin failed++; $display("FAIL resume_result: got %h expected 00000000", debug_result); end
    endtask

    task automatic test_reset_mid();
`ifdef DEBUG_MEM_ACCESS_EN
        frame(32'd1, 32'd0, 32'd0);
        wait_idle(8);
        frame(32'd6, 32'd0, 32'h0000_0300);
        @(negedge clk);
        tests++; if (mem_req !== 1'b1) begin failed++; $display("FAIL rmid_mem_req_before: got %b expected 1", mem_req); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tests++; if (mem_req !== 1'b0 || core_busy !== 1'b0) begin failed++; $display("FAIL rmid_mem_abort: got req=%b busy=%b expected 0/0", mem_req, core_busy); end
`endif
        frame(32'd1, 32'd0, 32'd0);
        wait_idle(8);
        frame(32'd3, 32'd0, 32'd0);
        @(negedge clk);
        tests++; if (core_busy !== 1'b1) begin failed++; $display("FAIL rmid_step_busy: got %b expected 1", core_busy); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tests++; if (core_busy !== 1'b0 || core_halt !== 1'b0) begin failed++; $display("FAIL rmid_step_abort: got busy=%b halt=%b expected 0/0", core_busy, core_halt); end
        tests++; if (debug_result !== 32'd0) begin failed++; $display("FAIL rmid_result: got %h expected 00000000", debug_result); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_not_halted();
        test_halt();
        test_registers();
        test_step();
        test_memory();
        test_restart();
        test_resume();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
